// File: rtl/wb_openram_multibank.sv
// wb_openram_multibank
// Wishbone classic slave that maps a window of the bus address space onto
// NUM_BANKS single-port OpenRAM macros. The macros share the write enable,
// byte mask, word address and write data; each bank has its own chip select.
// A read returns after READ_LATENCY extra cycles. If cyc drops mid-access,
// the access is abandoned without a response.
//
// Optional build macro: WB_OPENRAM_ERR_EN
//   defined   - an access to a bank index >= NUM_BANKS raises wbs_err_o
//   undefined - the same access is acked with zero read data; wbs_err_o is 0
module wb_openram_multibank #(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int          NUM_BANKS    = 2,
    parameter int          ADDR_WIDTH   = 8,
    parameter int          READ_LATENCY = 1
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_n_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_we_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [31:0]               wbs_dat_i,
    input  logic [31:0]               wbs_adr_i,
    output logic                      wbs_ack_o,
    output logic                      wbs_err_o,
    output logic [31:0]               wbs_dat_o,
    output logic                      sram_clk0,
    output logic [NUM_BANKS-1:0]      sram_csb0,
    output logic                      sram_web0,
    output logic [3:0]                sram_wmask0,
    output logic [ADDR_WIDTH-1:0]     sram_addr0,
    output logic [31:0]               sram_din0,
    input  logic [NUM_BANKS*32-1:0]   sram_dout0
);

    // Bank index width; a single bank needs no index bits in the address.
    localparam int BB      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
    localparam int BW      = (BB > 0) ? BB : 1;
    localparam int HIT_LSB = ADDR_WIDTH + 2 + BB;
    localparam int CW      = $clog2(READ_LATENCY + 1);

    localparam logic [BW:0]   NB_LIMIT = (BW + 1)'(NUM_BANKS);
    localparam logic [CW-1:0] LAT      = CW'(READ_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                 state_q,  state_d;
    logic [NUM_BANKS-1:0]   csb_q,    csb_d;
    logic                   web_q,    web_d;
    logic [3:0]             wmask_q,  wmask_d;
    logic [ADDR_WIDTH-1:0]  addr_q,   addr_d;
    logic [31:0]            din_q,    din_d;
    logic                   ack_q,    ack_d;
    logic                   err_q,    err_d;
    logic [31:0]            dat_q,    dat_d;
    logic [BW-1:0]          bank_q,   bank_d;
    logic                   we_q,     we_d;
    logic [CW-1:0]          cnt_q,    cnt_d;

    logic                   hit;
    logic                   req;
    logic                   bank_absent;
    logic [BW-1:0]          req_bank;
    logic [ADDR_WIDTH-1:0]  req_word;
    logic [31:0]            rd_word;

    // Address decode: window hit, bank index and word index of the request.
    always_comb begin
        hit         = ((wbs_adr_i >> HIT_LSB) == (BASE_ADDR >> HIT_LSB));
        req         = wbs_cyc_i & wbs_stb_i & hit;
        req_word    = wbs_adr_i[ADDR_WIDTH+1:2];
        req_bank    = (BB == 0) ? '0 : BW'(wbs_adr_i >> (ADDR_WIDTH + 2));
        bank_absent = ({1'b0, req_bank} >= NB_LIMIT);
    end

    // Read-data select: pick the slice of the bank latched at acceptance.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (bank_q == BW'(k)) begin
                rd_word = sram_dout0[32*k +: 32];
            end
        end
    end

    // Next-state and registered-output logic. Chip selects and write enable
    // default to inactive so they are only low for the single ACCESS cycle.
    always_comb begin
        state_d = state_q;
        csb_d   = '1;
        web_d   = 1'b1;
        wmask_d = wmask_q;
        addr_d  = addr_q;
        din_d   = din_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;
        bank_d  = bank_q;
        we_d    = we_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (bank_absent) begin
                        state_d = S_RESP;
`ifdef WB_OPENRAM_ERR_EN
                        err_d   = 1'b1;
`else
                        ack_d   = 1'b1;
                        dat_d   = '0;
`endif
                    end else begin
                        state_d = S_ACCESS;
                        for (int k = 0; k < NUM_BANKS; k++) begin
                            csb_d[k] = (req_bank != BW'(k));
                        end
                        web_d   = ~wbs_we_i;
                        wmask_d = wbs_we_i ? wbs_sel_i : 4'h0;
                        addr_d  = req_word;
                        din_d   = wbs_dat_i;
                        bank_d  = req_bank;
                        we_d    = wbs_we_i;
                    end
                end
            end

            // The macro captures at the end of this cycle, so an abandoned
            // write still lands in the array.
            S_ACCESS: begin
                if (!wbs_cyc_i) begin
                    state_d = S_IDLE;
                end else if (we_q) begin
                    state_d = S_RESP;
                    ack_d   = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = LAT;
                end
            end

            S_WAIT: begin
                if (!wbs_cyc_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(1)) begin
                    state_d = S_RESP;
                    ack_d   = 1'b1;
                    dat_d   = rd_word;
                end else begin
                    cnt_d   = cnt_q - CW'(1);
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, cleared immediately by the async reset.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= S_IDLE;
            csb_q   <= '1;
            web_q   <= 1'b1;
            wmask_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            bank_q  <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            bank_q  <= bank_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sram_clk0   = wb_clk_i;
    assign sram_csb0   = csb_q;
    assign sram_web0   = web_q;
    assign sram_wmask0 = wmask_q;
    assign sram_addr0  = addr_q;
    assign sram_din0   = din_q;
    assign wbs_ack_o   = ack_q;
    assign wbs_err_o   = err_q;
    assign wbs_dat_o   = dat_q;

endmodule

// File: tb/tb_wb_openram_multibank.sv
// Bench for wb_openram_multibank: three banks, 8-bit word address, one DUT with
// READ_LATENCY=1 and one with READ_LATENCY=3, each attached to a behavioural
// macro model. Expected bus results come from a word-array reference memory.
module tb_wb_openram_multibank;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          NB   = 3;
    localparam int          AW   = 8;
`ifdef WB_OPENRAM_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, mem_clr;
    logic          cyc, stb, cyc3, stb3, we;
    logic [3:0]    sel;
    logic [31:0]   dat_w, adr;

    logic          ack1, err1, sclk1, web1;
    logic [31:0]   dout1, din1;
    logic [NB-1:0] csb1;
    logic [3:0]    wmask1;
    logic [AW-1:0] addr1;
    logic [NB*32-1:0] sdout1;

    logic          ack3, err3, sclk3, web3;
    logic [31:0]   dout3, din3;
    logic [NB-1:0] csb3;
    logic [3:0]    wmask3;
    logic [AW-1:0] addr3;
    logic [NB*32-1:0] sdout3;

    wb_openram_multibank #(.BASE_ADDR(BASE), .NUM_BANKS(NB), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut1 (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_dat_i(dat_w), .wbs_adr_i(adr), .wbs_ack_o(ack1), .wbs_err_o(err1),
        .wbs_dat_o(dout1), .sram_clk0(sclk1), .sram_csb0(csb1), .sram_web0(web1),
        .sram_wmask0(wmask1), .sram_addr0(addr1), .sram_din0(din1), .sram_dout0(sdout1));

    wb_openram_multibank #(.BASE_ADDR(BASE), .NUM_BANKS(NB), .ADDR_WIDTH(AW), .READ_LATENCY(3)) dut3 (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wbs_stb_i(stb3), .wbs_cyc_i(cyc3), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_dat_i(dat_w), .wbs_adr_i(adr), .wbs_ack_o(ack3), .wbs_err_o(err3),
        .wbs_dat_o(dout3), .sram_clk0(sclk3), .sram_csb0(csb3), .sram_web0(web3),
        .sram_wmask0(wmask3), .sram_addr0(addr3), .sram_din0(din3), .sram_dout0(sdout3));

    // Behavioural macros: capture on the clock edge closing a chip-select cycle,
    // read data appears 1 (dut1) or 3 (dut3) register stages later.
    logic [31:0] mem1 [NB][1<<AW];
    logic [31:0] mem3 [NB][1<<AW];
    logic [31:0] q1 [NB];
    logic [31:0] q3 [NB][3];
    logic [31:0] nw1, nw3;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int b = 0; b < NB; b++) begin
                for (int w = 0; w < (1<<AW); w++) begin
                    mem1[b][w] <= '0;
                    mem3[b][w] <= '0;
                end
                q1[b] <= '0;
                for (int s = 0; s < 3; s++) q3[b][s] <= '0;
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (!csb1[b]) begin
                    if (!web1) begin
                        nw1 = mem1[b][addr1];
                        for (int i = 0; i < 4; i++) if (wmask1[i]) nw1[8*i +: 8] = din1[8*i +: 8];
                        mem1[b][addr1] <= nw1;
                    end else begin
                        q1[b] <= mem1[b][addr1];
                    end
                end
                q3[b][2] <= q3[b][1];
                q3[b][1] <= q3[b][0];
                if (!csb3[b]) begin
                    if (!web3) begin
                        nw3 = mem3[b][addr3];
                        for (int i = 0; i < 4; i++) if (wmask3[i]) nw3[8*i +: 8] = din3[8*i +: 8];
                        mem3[b][addr3] <= nw3;
                    end else begin
                        q3[b][0] <= mem3[b][addr3];
                    end
                end
            end
        end
    end

    always_comb begin
        sdout1 = '0;
        sdout3 = '0;
        for (int b = 0; b < NB; b++) begin
            sdout1[32*b +: 32] = q1[b];
            sdout3[32*b +: 32] = q3[b][2];
        end
    end

    // Reference state: bus-visible memory contents and dut1's held read data.
    logic [31:0] ref_mem [NB][1<<AW];
    logic [31:0] exp_dat;
    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
    endtask

    task automatic release_bus();
        cyc = 1'b0; stb = 1'b0; cyc3 = 1'b0; stb3 = 1'b0; we = 1'b0;
    endtask

    // One Wishbone cycle on dut1 (which=1) or dut3 (which=3). lat is the
    // number of cycles from presentation to response, -1 if none came.
    task automatic wb_xfer(input int which, input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, output int lat, output logic e, output logic [31:0] rd);
        logic r_ack, r_err;
        @(negedge clk);
        we = w; adr = a; sel = s; dat_w = d;
        if (which == 3) begin cyc3 = 1'b1; stb3 = 1'b1; end
        else begin cyc = 1'b1; stb = 1'b1; end
        lat = -1; e = 1'b0; rd = '0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            r_ack = (which == 3) ? ack3 : ack1;
            r_err = (which == 3) ? err3 : err1;
            if (r_ack || r_err) begin
                lat = n;
                e   = r_err;
                rd  = (which == 3) ? dout3 : dout1;
                break;
            end
        end
        release_bus();
    endtask

    // Bus-level operation on dut1 checked against the reference memory.
    task automatic do_op(input logic w, input int b, input int wd, input logic [3:0] s,
                         input logic [31:0] d, input string tag);
        logic [31:0] a, rd;
        logic        e;
        int          lat;
        a = BASE + 32'(b * 1024 + wd * 4) + 32'($urandom_range(0, 3));
        wb_xfer(1, w, a, s, d, lat, e, rd);
        if (b >= NB) begin
            exp_dat = ERR_EN ? exp_dat : 32'h0;
            check_eq({tag, "_abs_lat"}, 32'(lat), 32'd1);
            check_eq({tag, "_abs_err"}, 32'(e), 32'(ERR_EN));
            check_eq({tag, "_abs_dat"}, rd, exp_dat);
        end else if (w) begin
            for (int i = 0; i < 4; i++) if (s[i]) ref_mem[b][wd][8*i +: 8] = d[8*i +: 8];
            check_eq({tag, "_wr_lat"}, 32'(lat), 32'd2);
            check_eq({tag, "_wr_err"}, 32'(e), 32'd0);
            check_eq({tag, "_wr_hold"}, rd, exp_dat);
        end else begin
            exp_dat = ref_mem[b][wd];
            check_eq({tag, "_rd_lat"}, 32'(lat), 32'd3);
            check_eq({tag, "_rd_err"}, 32'(e), 32'd0);
            check_eq({tag, "_rd_dat"}, rd, exp_dat);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        seen, e;
        logic [31:0] rd;
        int          lat;

        rst_n = 1'b0; mem_clr = 1'b1;
        cyc = 1'b0; stb = 1'b0; cyc3 = 1'b0; stb3 = 1'b0; we = 1'b0;
        sel = '0; dat_w = '0; adr = '0;
        exp_dat = '0;
        for (int b = 0; b < NB; b++)
            for (int w = 0; w < (1<<AW); w++) ref_mem[b][w] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_csb", 32'(csb1), 32'h7);
        check_eq("rst_web", 32'(web1), 32'd1);
        check_eq("rst_wmask", 32'(wmask1), 32'd0);
        check_eq("rst_addr", 32'(addr1), 32'd0);
        check_eq("rst_din", din1, 32'd0);
        check_eq("rst_ack", 32'(ack1), 32'd0);
        check_eq("rst_err", 32'(err1), 32'd0);
        check_eq("rst_dat", dout1, 32'd0);
        rst_n = 1'b1; mem_clr = 1'b0;

        // Full write to bank 1 word 1 with macro-side timing
        @(negedge clk); drive(1'b1, 32'h3000_0404, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        check_eq("w1_csb", 32'(csb1), 32'h5);
        check_eq("w1_web", 32'(web1), 32'd0);
        check_eq("w1_addr", 32'(addr1), 32'h01);
        check_eq("w1_wmask", 32'(wmask1), 32'hF);
        check_eq("w1_din", din1, 32'hDEADBEEF);
        check_eq("w1_ack_early", 32'(ack1), 32'd0);
        @(negedge clk);
        check_eq("w1_ack", 32'(ack1), 32'd1);
        check_eq("w1_csb_rel", 32'(csb1), 32'h7);
        release_bus();
        @(negedge clk);
        check_eq("w1_ack_once", 32'(ack1), 32'd0);
        ref_mem[1][1] = 32'hDEADBEEF;

        // Read back with cycle-exact ack
        @(negedge clk); drive(1'b0, 32'h3000_0404, 4'hF, 32'h0);
        @(negedge clk);
        check_eq("r1_csb", 32'(csb1), 32'h5);
        check_eq("r1_web", 32'(web1), 32'd1);
        check_eq("r1_wmask", 32'(wmask1), 32'd0);
        @(negedge clk);
        check_eq("r1_ack_early", 32'(ack1), 32'd0);
        @(negedge clk);
        check_eq("r1_ack", 32'(ack1), 32'd1);
        check_eq("r1_dat", dout1, 32'hDEADBEEF);
        release_bus();
        exp_dat = 32'hDEADBEEF;

        // Byte-lane write into bank 0 word 2
        do_op(1'b1, 0, 2, 4'hF, 32'h11223344, "bl_init");
        @(negedge clk); drive(1'b1, 32'h3000_0008, 4'b0010, 32'h0000AA00);
        @(negedge clk);
        check_eq("bl_csb", 32'(csb1), 32'h6);
        check_eq("bl_addr", 32'(addr1), 32'h02);
        check_eq("bl_wmask", 32'(wmask1), 32'h2);
        @(negedge clk);
        check_eq("bl_ack", 32'(ack1), 32'd1);
        release_bus();
        ref_mem[0][2][15:8] = 8'hAA;
        do_op(1'b0, 0, 2, 4'hF, 32'h0, "bl_rd");

        // Absent bank 3 responds in the next cycle with no chip select
        @(negedge clk); drive(1'b0, 32'h3000_0C10, 4'hF, 32'h0);
        @(negedge clk);
        exp_dat = ERR_EN ? exp_dat : 32'h0;
        check_eq("abs_csb", 32'(csb1), 32'h7);
        check_eq("abs_ack", 32'(ack1), 32'(!ERR_EN));
        check_eq("abs_err", 32'(err1), 32'(ERR_EN));
        check_eq("abs_dat", dout1, exp_dat);
        release_bus();
        @(negedge clk);
        check_eq("abs_once", 32'(ack1 | err1), 32'd0);

        // Outside the window: nothing at all
        @(negedge clk); drive(1'b0, 32'h3100_0000, 4'hF, 32'h0);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | ack1 | err1 | (csb1 != 3'b111);
        end
        release_bus();
        check_eq("oow_quiet", 32'(seen), 32'd0);

        // Asynchronous reset while a read is waiting
        do_op(1'b0, 1, 1, 4'hF, 32'h0, "pre_rst");
        @(negedge clk); drive(1'b0, 32'h3000_0404, 4'hF, 32'hCAFEF00D);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("arst_csb", 32'(csb1), 32'h7);
        check_eq("arst_web", 32'(web1), 32'd1);
        check_eq("arst_addr", 32'(addr1), 32'd0);
        check_eq("arst_din", din1, 32'd0);
        check_eq("arst_ack", 32'(ack1), 32'd0);
        check_eq("arst_dat", dout1, 32'd0);
        release_bus();
        @(negedge clk);
        rst_n = 1'b1;
        exp_dat = '0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | ack1 | err1;
        end
        check_eq("arst_no_ack", 32'(seen), 32'd0);
        do_op(1'b1, 2, 7, 4'hF, 32'h0F0E0D0C, "post_rst");

        // Read abandoned in ACCESS, then a write straight afterwards
        @(negedge clk); drive(1'b0, 32'h3000_0008, 4'hF, 32'h0);
        @(negedge clk); release_bus();
        do_op(1'b1, 2, 5, 4'hF, 32'h600DCAFE, "abt_next");
        do_op(1'b0, 2, 5, 4'hF, 32'h0, "abt_rb");

        // Write abandoned in ACCESS still lands in the macro
        @(negedge clk); drive(1'b1, 32'h3000_0424, 4'hF, 32'h5A5A1234);
        @(negedge clk); release_bus();
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | ack1 | err1;
        end
        check_eq("abtw_no_ack", 32'(seen), 32'd0);
        ref_mem[1][9] = 32'h5A5A1234;
        do_op(1'b0, 1, 9, 4'hF, 32'h0, "abtw_rb");

        // READ_LATENCY=3 instance
        wb_xfer(3, 1'b1, 32'h3000_0404, 4'hF, 32'h0BADF00D, lat, e, rd);
        check_eq("rl3_wr_lat", 32'(lat), 32'd2);
        wb_xfer(3, 1'b0, 32'h3000_0404, 4'hF, 32'h0, lat, e, rd);
        check_eq("rl3_rd_lat", 32'(lat), 32'd5);
        check_eq("rl3_rd_dat", rd, 32'h0BADF00D);
        check_eq("rl3_rd_err", 32'(e), 32'd0);

        // Randomised back-to-back traffic over a small word range
        for (int i = 0; i < 150; i++) begin
            int b, wd;
            b  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            wd = int'($urandom_range(0, 7));
            do_op(1'($urandom_range(0, 1)), b, wd, 4'($urandom_range(0, 15)), $urandom, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_openram_multibank.md
Name: wb_openram_multibank

Overview:
Wishbone classic slave that maps a window of the user address space onto NUM_BANKS OpenRAM single-port (RW port 0) macros. It is the parametrised successor of the single-macro Wishbone/OpenRAM bridge. Added capabilities: multi-bank decode, configurable macro depth, configurable read latency, and cycle-abort handling. It sits in user_project_wrapper between the Wishbone slave port and the bank of sky130 SRAM macros.

Parameters:
BASE_ADDR, 32'h3000_0000, byte base of the window; the bits below the window size are ignored.
NUM_BANKS, 2, number of macros (1..8, any value).
ADDR_WIDTH, 8, word-address width of one macro (bank size = 4*2^ADDR_WIDTH bytes).
READ_LATENCY, 1, cycles from the SRAM capture edge until sram_dout0 is valid (1..4).

Ports:
wb_clk_i  in  1  system clock
wb_rst_n_i  in  1  asynchronous active-low reset
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects
wbs_dat_i  in  32  write data
wbs_adr_i  in  32  byte address
wbs_ack_o  out  1  acknowledge
wbs_err_o  out  1  error (see Optional Feature)
wbs_dat_o  out  32  read data
sram_clk0  out  1  macro clock, = wb_clk_i
sram_csb0  out  NUM_BANKS  per-bank active-low chip select
sram_web0  out  1  shared active-low write enable
sram_wmask0  out  4  shared byte write mask
sram_addr0  out  ADDR_WIDTH  shared word address
sram_din0  out  32  shared write data
sram_dout0  in  NUM_BANKS*32  bank k read data occupies bits [32k+31:32k]

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_n_i is asynchronous, active-low.
- Reset values: sram_csb0 all 1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0, wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0, FSM=IDLE. Reset takes effect immediately, including mid-transaction.
- Decode:
  - BB = clog2(NUM_BANKS), with BB=0 when NUM_BANKS=1.
  - word = adr[ADDR_WIDTH+1:2].
  - bank = adr[ADDR_WIDTH+1+BB:ADDR_WIDTH+2].
  - hit = adr[31:ADDR_WIDTH+2+BB] equals the same bits of BASE_ADDR.
- req = cyc & stb & hit. A non-hit address produces no response.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE, on req in cycle T:
  - bank < NUM_BANKS: register csb0[bank]=0, web0=~we, wmask0=sel (0 for reads), addr0=word, din0=dat_i. These are visible in T+1. Go to ACCESS.
  - bank >= NUM_BANKS (absent bank): no csb asserted; go to RESP with absent flag.
- ACCESS (T+1): the macro captures at the end of this cycle. All csb return to 1 and web0 returns to 1 next cycle.
  - Write: go to RESP.
  - Read: go to WAIT with counter = READ_LATENCY.
- WAIT: decrement each cycle. At 1, register sram_dout0 slice of the latched bank into wbs_dat_o and go to RESP.
- RESP: one cycle; wbs_ack_o (or err) = 1. Then return to IDLE.
- Latency:
  - Write ack in T+2.
  - Read ack in T+2+READ_LATENCY, with wbs_dat_o valid in the same cycle.
  - Absent bank: response in T+1.
  - wbs_dat_o holds its value until the next read completes.
- Back-to-back: a new request presented the cycle after RESP is accepted in IDLE. Requests are never accepted outside IDLE, and stb held during RESP is not re-accepted.
- Abort: if cyc drops in ACCESS or WAIT, go to IDLE with no ack. A write already captured by the macro stands.
- Bank, we and word are latched at acceptance; the bus may change afterwards.

Optional Feature:
WB_OPENRAM_ERR_EN
- Defined: an absent-bank access asserts wbs_err_o for one cycle (T+1), with wbs_ack_o=0 and wbs_dat_o unchanged.
- Undefined: wbs_err_o is tied 0; an absent-bank access acks in T+1 with wbs_dat_o=0, and writes are discarded.

Test Plan:
All scenarios use BASE_ADDR=0x3000_0000, NUM_BANKS=3, ADDR_WIDTH=8, READ_LATENCY=1, with a behavioural macro model.
1. Write 0xDEADBEEF to 0x3000_0404, sel=0xF, at T -> in T+1 csb0=3'b101, web0=0, addr0=0x01, wmask0=0xF, din0=0xDEADBEEF; ack in T+2 only.
2. Read 0x3000_0404 at T -> csb0[1]=0 and web0=1 in T+1; ack in T+3 with wbs_dat_o=0xDEADBEEF. Repeat with READ_LATENCY=3 -> ack in T+5.
3. Write sel=4'b0010, data 0x0000AA00, to 0x3000_0008 -> bank 0, addr0=0x02, wmask0=0x2; read back returns the prior word with only byte1 = 0xAA.
4. Access 0x3000_0C10 (bank 3, absent) -> with ERR_EN: err in T+1, no csb low; without: ack in T+1, dat=0. Access 0x3100_0000 -> no ack, no err, no csb.
5. Read issued, then wb_rst_n_i low during WAIT -> all outputs at reset values asynchronously; no ack after release; next write completes normally.
6. Read issued, cyc dropped in ACCESS -> no ack; FSM back in IDLE; a write presented next cycle acks 2 cycles later.
